aes_key_expand: RTL and testbench
=================================

# aes_key_expand

AES-128 key-expansion stage that sits directly upstream of the AddRoundKey pipeline stages. It accepts a 128-bit cipher key on a start pulse and emits round keys 0 through 10 one at a time over a valid/ready handshake. Round key 0 feeds the initial AddRoundKey stage; round keys 1–10 feed the round stages or a key buffer. Each round key is computed on the fly from the previous one with one S-box lookup per byte of the last word, so no 1408-bit key schedule is stored.

## Interface
- No parameters. Fixed at AES-128: Nk=4, 10 rounds.
- clk  in  1  clock; all flops on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request expansion; sampled only in IDLE.
- key_in  in  128  cipher key, latched on accepted start; bits [127:96] = w0, byte 0 in [127:120].
- rk_ready  in  1  downstream accepts current round key.
- rk_valid  out  1  round_key/rk_idx valid.
- rk_idx  out  4  index of current round key, 0..10.
- round_key  out  128  current round key, same word/byte order as key_in.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after round key 10 is accepted.

## Operation
- FSM states: IDLE, RUN.
- IDLE to RUN occurs on a clock edge with start=1:
  - round_key <= key_in; rk_idx <= 0; rk_valid <= 1.
- In RUN, a handshake is rk_valid && rk_ready:
  - Handshake with rk_idx<10: round_key <= next(round_key, rcon[rk_idx]); rk_idx <= rk_idx+1; rk_valid stays 1.
  - Handshake with rk_idx==10: go to IDLE; rk_valid <= 0; done <= 1 for one cycle. round_key and rk_idx hold their values.
  - No handshake: round_key, rk_idx and rk_valid hold exactly (stall).
- next() follows FIPS-197 with prior words w0..w3:
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}.
  - RotWord(x) = {x[23:0], x[31:24]}.
  - n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2.
- rcon for idx 0..9: 01,02,04,08,10,20,40,80,1B,36. Use a case ROM, not xtime.
- SubWord uses 4 combinational copies of the standard AES forward S-box (256x8 case ROM).
- start while busy=1 is ignored; key_in is not re-latched.
- start in the same cycle that done=1 is accepted, because the FSM is already in IDLE.
- key_in is don't-care except on an accepted start edge.

## Timing
- Reset values: rk_valid=0, rk_idx=0, round_key=0, busy=0, done=0, FSM=IDLE.
- All outputs are registered; there is no combinational path from any input to any output.
- Start accepted at edge E: rk_valid=1 and rk_idx=0 from E+1.
- With rk_ready held at 1: rk_idx steps 0..10 on consecutive cycles E+1..E+11; done=1 in cycle E+12; busy=1 in cycles E+1..E+11.
- Each cycle with rk_ready=0 adds one cycle of latency and keeps the outputs frozen.
- Critical path: S-box, then a 4-deep XOR chain. This meets the single-cycle requirement at the system clock.
- Reset asserted mid-expansion: immediate return to reset values, no done pulse. The next start begins from rk_idx 0.

## Test plan
- FIPS-197 A.1 key:
  - Stimulus: key_in=2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1.
  - Required: idx0 = key_in; idx1 = a0fafe1788542cb123a339392a6c7605; idx2 = f2c295f27a96b9435935807a7359f67f; idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Required: done one cycle after idx10, exactly 12 cycles after start.
- Zero key:
  - Stimulus: key_in=0.
  - Required: idx1 = 62636363626363636263636362636363.
  - Required: all 11 keys match a reference model.
- Backpressure:
  - Stimulus: same key as A.1, rk_ready toggled randomly, including 5-cycle stalls at idx0 and idx10.
  - Required: outputs stable during stalls; each idx delivered exactly once, in order; same key values as A.1.
- Ignored start:
  - Stimulus: pulse start with a different key_in at idx 4.
  - Required: sequence unaffected.
- Back-to-back:
  - Stimulus: start asserted in the done cycle.
  - Required: new idx0 appears the next cycle.
- Async reset:
  - Stimulus: assert reset between edges at idx 6.
  - Required: outputs go to 0 without waiting for a clock edge; no done pulse.
  - Required: a restart yields the correct full sequence.

Source files
------------

// File: rtl/aes_key_expand_if.sv
// Key-expansion handshake bundle: start/key request in, round-key stream out.
// The master side is the requester/consumer; the slave side is aes_key_expand.
interface aes_key_expand_if;
    logic         start;
    logic [127:0] key_in;
    logic         rk_ready;
    logic         rk_valid;
    logic [3:0]   rk_idx;
    logic [127:0] round_key;
    logic         busy;
    logic         done;

    modport master (
        output start, key_in, rk_ready,
        input  rk_valid, rk_idx, round_key, busy, done
    );

    modport slave (
        input  start, key_in, rk_ready,
        output rk_valid, rk_idx, round_key, busy, done
    );
endinterface

// File: rtl/aes_key_expand.sv
// AES-128 on-the-fly key expansion: emits round keys 0..10 over valid/ready,
// deriving each key from the previous one so no full schedule is stored.
//
// state | meaning
// IDLE  | waiting for start; rk_valid low
// RUN   | presenting round key rk_idx, advancing on each handshake
module aes_key_expand (
    input  logic             clk,
    input  logic             reset,
    aes_key_expand_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t       state, state_next;
    logic [127:0] round_key_q, round_key_next, round_key_exp;
    logic [3:0]   rk_idx_q, rk_idx_next;
    logic         rk_valid_q, rk_valid_next;
    logic         done_q, done_next;
    logic [31:0]  w0, w1, w2, w3, rot_w, t_w, n0, n1, n2, n3;

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        rcon = 8'h00;
        case (idx)
            4'd0: rcon = 8'h01;  4'd1: rcon = 8'h02;  4'd2: rcon = 8'h04;  4'd3: rcon = 8'h08;
            4'd4: rcon = 8'h10;  4'd5: rcon = 8'h20;  4'd6: rcon = 8'h40;  4'd7: rcon = 8'h80;
            4'd8: rcon = 8'h1b;  4'd9: rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        sbox = 8'h00;
        case (x)
            8'h00: sbox = 8'h63; 8'h01: sbox = 8'h7c; 8'h02: sbox = 8'h77; 8'h03: sbox = 8'h7b; 8'h04: sbox = 8'hf2; 8'h05: sbox = 8'h6b; 8'h06: sbox = 8'h6f; 8'h07: sbox = 8'hc5;
            8'h08: sbox = 8'h30; 8'h09: sbox = 8'h01; 8'h0a: sbox = 8'h67; 8'h0b: sbox = 8'h2b; 8'h0c: sbox = 8'hfe; 8'h0d: sbox = 8'hd7; 8'h0e: sbox = 8'hab; 8'h0f: sbox = 8'h76;
            8'h10: sbox = 8'hca; 8'h11: sbox = 8'h82; 8'h12: sbox = 8'hc9; 8'h13: sbox = 8'h7d; 8'h14: sbox = 8'hfa; 8'h15: sbox = 8'h59; 8'h16: sbox = 8'h47; 8'h17: sbox = 8'hf0;
            8'h18: sbox = 8'had; 8'h19: sbox = 8'hd4; 8'h1a: sbox = 8'ha2; 8'h1b: sbox = 8'haf; 8'h1c: sbox = 8'h9c; 8'h1d: sbox = 8'ha4; 8'h1e: sbox = 8'h72; 8'h1f: sbox = 8'hc0;
            8'h20: sbox = 8'hb7; 8'h21: sbox = 8'hfd; 8'h22: sbox = 8'h93; 8'h23: sbox = 8'h26; 8'h24: sbox = 8'h36; 8'h25: sbox = 8'h3f; 8'h26: sbox = 8'hf7; 8'h27: sbox = 8'hcc;
            8'h28: sbox = 8'h34; 8'h29: sbox = 8'ha5; 8'h2a: sbox = 8'he5; 8'h2b: sbox = 8'hf1; 8'h2c: sbox = 8'h71; 8'h2d: sbox = 8'hd8; 8'h2e: sbox = 8'h31; 8'h2f: sbox = 8'h15;
            8'h30: sbox = 8'h04; 8'h31: sbox = 8'hc7; 8'h32: sbox = 8'h23; 8'h33: sbox = 8'hc3; 8'h34: sbox = 8'h18; 8'h35: sbox = 8'h96; 8'h36: sbox = 8'h05; 8'h37: sbox = 8'h9a;
            8'h38: sbox = 8'h07; 8'h39: sbox = 8'h12; 8'h3a: sbox = 8'h80; 8'h3b: sbox = 8'he2; 8'h3c: sbox = 8'heb; 8'h3d: sbox = 8'h27; 8'h3e: sbox = 8'hb2; 8'h3f: sbox = 8'h75;
            8'h40: sbox = 8'h09; 8'h41: sbox = 8'h83; 8'h42: sbox = 8'h2c; 8'h43: sbox = 8'h1a; 8'h44: sbox = 8'h1b; 8'h45: sbox = 8'h6e; 8'h46: sbox = 8'h5a; 8'h47: sbox = 8'ha0;
            8'h48: sbox = 8'h52; 8'h49: sbox = 8'h3b; 8'h4a: sbox = 8'hd6; 8'h4b: sbox = 8'hb3; 8'h4c: sbox = 8'h29; 8'h4d: sbox = 8'he3; 8'h4e: sbox = 8'h2f; 8'h4f: sbox = 8'h84;
            8'h50: sbox = 8'h53; 8'h51: sbox = 8'hd1; 8'h52: sbox = 8'h00; 8'h53: sbox = 8'hed; 8'h54: sbox = 8'h20; 8'h55: sbox = 8'hfc; 8'h56: sbox = 8'hb1; 8'h57: sbox = 8'h5b;
            8'h58: sbox = 8'h6a; 8'h59: sbox = 8'hcb; 8'h5a: sbox = 8'hbe; 8'h5b: sbox = 8'h39; 8'h5c: sbox = 8'h4a; 8'h5d: sbox = 8'h4c; 8'h5e: sbox = 8'h58; 8'h5f: sbox = 8'hcf;
            8'h60: sbox = 8'hd0; 8'h61: sbox = 8'hef; 8'h62: sbox = 8'haa; 8'h63: sbox = 8'hfb; 8'h64: sbox = 8'h43; 8'h65: sbox = 8'h4d; 8'h66: sbox = 8'h33; 8'h67: sbox = 8'h85;
            8'h68: sbox = 8'h45; 8'h69: sbox = 8'hf9; 8'h6a: sbox = 8'h02; 8'h6b: sbox = 8'h7f; 8'h6c: sbox = 8'h50; 8'h6d: sbox = 8'h3c; 8'h6e: sbox = 8'h9f; 8'h6f: sbox = 8'ha8;
            8'h70: sbox = 8'h51; 8'h71: sbox = 8'ha3; 8'h72: sbox = 8'h40; 8'h73: sbox = 8'h8f; 8'h74: sbox = 8'h92; 8'h75: sbox = 8'h9d; 8'h76: sbox = 8'h38; 8'h77: sbox = 8'hf5;
            8'h78: sbox = 8'hbc; 8'h79: sbox = 8'hb6; 8'h7a: sbox = 8'hda; 8'h7b: sbox = 8'h21; 8'h7c: sbox = 8'h10; 8'h7d: sbox = 8'hff; 8'h7e: sbox = 8'hf3; 8'h7f: sbox = 8'hd2;
            8'h80: sbox = 8'hcd; 8'h81: sbox = 8'h0c; 8'h82: sbox = 8'h13; 8'h83: sbox = 8'hec; 8'h84: sbox = 8'h5f; 8'h85: sbox = 8'h97; 8'h86: sbox = 8'h44; 8'h87: sbox = 8'h17;
            8'h88: sbox = 8'hc4; 8'h89: sbox = 8'ha7; 8'h8a: sbox = 8'h7e; 8'h8b: sbox = 8'h3d; 8'h8c: sbox = 8'h64; 8'h8d: sbox = 8'h5d; 8'h8e: sbox = 8'h19; 8'h8f: sbox = 8'h73;
            8'h90: sbox = 8'h60; 8'h91: sbox = 8'h81; 8'h92: sbox = 8'h4f; 8'h93: sbox = 8'hdc; 8'h94: sbox = 8'h22; 8'h95: sbox = 8'h2a; 8'h96: sbox = 8'h90; 8'h97: sbox = 8'h88;
            8'h98: sbox = 8'h46; 8'h99: sbox = 8'hee; 8'h9a: sbox = 8'hb8; 8'h9b: sbox = 8'h14; 8'h9c: sbox = 8'hde; 8'h9d: sbox = 8'h5e; 8'h9e: sbox = 8'h0b; 8'h9f: sbox = 8'hdb;
            8'ha0: sbox = 8'he0; 8'ha1: sbox = 8'h32; 8'ha2: sbox = 8'h3a; 8'ha3: sbox = 8'h0a; 8'ha4: sbox = 8'h49; 8'ha5: sbox = 8'h06; 8'ha6: sbox = 8'h24; 8'ha7: sbox = 8'h5c;
            8'ha8: sbox = 8'hc2; 8'ha9: sbox = 8'hd3; 8'haa: sbox = 8'hac; 8'hab: sbox = 8'h62; 8'hac: sbox = 8'h91; 8'had: sbox = 8'h95; 8'hae: sbox = 8'he4; 8'haf: sbox = 8'h79;
            8'hb0: sbox = 8'he7; 8'hb1: sbox = 8'hc8; 8'hb2: sbox = 8'h37; 8'hb3: sbox = 8'h6d; 8'hb4: sbox = 8'h8d; 8'hb5: sbox = 8'hd5; 8'hb6: sbox = 8'h4e; 8'hb7: sbox = 8'ha9;
            8'hb8: sbox = 8'h6c; 8'hb9: sbox = 8'h56; 8'hba: sbox = 8'hf4; 8'hbb: sbox = 8'hea; 8'hbc: sbox = 8'h65; 8'hbd: sbox = 8'h7a; 8'hbe: sbox = 8'hae; 8'hbf: sbox = 8'h08;
            8'hc0: sbox = 8'hba; 8'hc1: sbox = 8'h78; 8'hc2: sbox = 8'h25; 8'hc3: sbox = 8'h2e; 8'hc4: sbox = 8'h1c; 8'hc5: sbox = 8'ha6; 8'hc6: sbox = 8'hb4; 8'hc7: sbox = 8'hc6;
            8'hc8: sbox = 8'he8; 8'hc9: sbox = 8'hdd; 8'hca: sbox = 8'h74; 8'hcb: sbox = 8'h1f; 8'hcc: sbox = 8'h4b; 8'hcd: sbox = 8'hbd; 8'hce: sbox = 8'h8b; 8'hcf: sbox = 8'h8a;
            8'hd0: sbox = 8'h70; 8'hd1: sbox = 8'h3e; 8'hd2: sbox = 8'hb5; 8'hd3: sbox = 8'h66; 8'hd4: sbox = 8'h48; 8'hd5: sbox = 8'h03; 8'hd6: sbox = 8'hf6; 8'hd7: sbox = 8'h0e;
            8'hd8: sbox = 8'h61; 8'hd9: sbox = 8'h35; 8'hda: sbox = 8'h57; 8'hdb: sbox = 8'hb9; 8'hdc: sbox = 8'h86; 8'hdd: sbox = 8'hc1; 8'hde: sbox = 8'h1d; 8'hdf: sbox = 8'h9e;
            8'he0: sbox = 8'he1; 8'he1: sbox = 8'hf8; 8'he2: sbox = 8'h98; 8'he3: sbox = 8'h11; 8'he4: sbox = 8'h69; 8'he5: sbox = 8'hd9; 8'he6: sbox = 8'h8e; 8'he7: sbox = 8'h94;
            8'he8: sbox = 8'h9b; 8'he9: sbox = 8'h1e; 8'hea: sbox = 8'h87; 8'heb: sbox = 8'he9; 8'hec: sbox = 8'hce; 8'hed: sbox = 8'h55; 8'hee: sbox = 8'h28; 8'hef: sbox = 8'hdf;
            8'hf0: sbox = 8'h8c; 8'hf1: sbox = 8'ha1; 8'hf2: sbox = 8'h89; 8'hf3: sbox = 8'h0d; 8'hf4: sbox = 8'hbf; 8'hf5: sbox = 8'he6; 8'hf6: sbox = 8'h42; 8'hf7: sbox = 8'h68;
            8'hf8: sbox = 8'h41; 8'hf9: sbox = 8'h99; 8'hfa: sbox = 8'h2d; 8'hfb: sbox = 8'h0f; 8'hfc: sbox = 8'hb0; 8'hfd: sbox = 8'h54; 8'hfe: sbox = 8'hbb; 8'hff: sbox = 8'h16;
        endcase
    endfunction

    // Next round key: one SubWord (four S-box copies) then the w0..w3 XOR chain.
    always_comb begin
        w0    = round_key_q[127:96];
        w1    = round_key_q[95:64];
        w2    = round_key_q[63:32];
        w3    = round_key_q[31:0];
        rot_w = {w3[23:0], w3[31:24]};
        t_w   = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])}
                ^ {rcon(rk_idx_q), 24'h000000};
        n0    = w0 ^ t_w;
        n1    = w1 ^ n0;
        n2    = w2 ^ n1;
        n3    = w3 ^ n2;
        round_key_exp = {n0, n1, n2, n3};
    end

    always_comb begin
        state_next     = state;
        round_key_next = round_key_q;
        rk_idx_next    = rk_idx_q;
        rk_valid_next  = rk_valid_q;
        done_next      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next     = RUN;
                    round_key_next = bus.key_in;
                    rk_idx_next    = 4'd0;
                    rk_valid_next  = 1'b1;
                end
            end
            RUN: begin
                if (rk_valid_q && bus.rk_ready) begin
                    if (rk_idx_q == 4'd10) begin
                        // Last key accepted: key and index are left as-is.
                        state_next    = IDLE;
                        rk_valid_next = 1'b0;
                        done_next     = 1'b1;
                    end else begin
                        round_key_next = round_key_exp;
                        rk_idx_next    = rk_idx_q + 4'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            round_key_q <= 128'h0;
            rk_idx_q    <= 4'd0;
            rk_valid_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_next;
            round_key_q <= round_key_next;
            rk_idx_q    <= rk_idx_next;
            rk_valid_q  <= rk_valid_next;
            done_q      <= done_next;
        end
    end

    assign bus.round_key = round_key_q;
    assign bus.rk_idx    = rk_idx_q;
    assign bus.rk_valid  = rk_valid_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state == RUN);
endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand; expected keys come from an independent
// model whose S-box is derived from the GF(2^8) inverse plus affine map.
module tb_aes_key_expand;
    logic clk = 1'b0;
    logic reset;
    aes_key_expand_if bus ();

    aes_key_expand dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A1_K1    = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A1_K2    = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] A1_K10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_K1  = 128'h62636363626363636263636362636363;

    logic [7:0]   sbox_tab [0:255];
    logic [127:0] exp_key  [0:10];
    logic [127:0] got_key  [0:10];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int b = 1; b < 256; b++)
            if (x != 8'h00 && gmul(x, 8'(b)) == 8'h01) inv = 8'(b);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] next_ref(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w3, rot, t, n0, n1, n2, n3;
        w3  = k[31:0];
        rot = {w3[23:0], w3[31:24]};
        t   = {sbox_tab[rot[31:24]], sbox_tab[rot[23:16]], sbox_tab[rot[15:8]], sbox_tab[rot[7:0]]}
              ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    task automatic compute_schedule(input logic [127:0] key);
        logic [7:0] rc;
        rc = 8'h01;
        exp_key[0] = key;
        for (int i = 1; i <= 10; i++) begin
            exp_key[i] = next_ref(exp_key[i-1], rc);
            rc = xtime(rc);
        end
    endtask

    // Returns at the negedge of the first cycle after the accepting edge.
    task automatic do_start(input logic [127:0] key);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.key_in = key;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.key_in = 128'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.rk_valid !== 1'b0 || bus.rk_idx !== 4'd0 || bus.round_key !== 128'h0 ||
            bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: valid=%b idx=%0d key=%h busy=%b done=%b, want all zero",
                     bus.rk_valid, bus.rk_idx, bus.round_key, bus.busy, bus.done);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.rk_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: valid=%b busy=%b done=%b, want 0 0 0",
                     bus.rk_valid, bus.busy, bus.done);
        end
    endtask

    task automatic test_fips();
        compute_schedule(KEY_A1);
        bus.rk_ready = 1'b1;
        do_start(KEY_A1);
        for (int i = 0; i <= 10; i++) begin
            got_key[i] = bus.round_key;
            checks++;
            if (bus.rk_valid !== 1'b1 || bus.rk_idx !== 4'(i) || bus.round_key !== exp_key[i]) begin
                errors++;
                $display("FAIL fips_key: valid=%b idx=%0d key=%h, want valid=1 idx=%0d key=%h",
                         bus.rk_valid, bus.rk_idx, bus.round_key, i, exp_key[i]);
            end
            checks++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL fips_busy idx %0d: busy=%b done=%b, want 1 0", i, bus.busy, bus.done);
            end
            @(negedge clk);
        end
        checks++;
        if (bus.done !== 1'b1 || bus.rk_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.rk_idx !== 4'd10 || bus.round_key !== exp_key[10]) begin
            errors++;
            $display("FAIL fips_done_cycle12: done=%b valid=%b busy=%b idx=%0d key=%h, want 1 0 0 10 %h",
                     bus.done, bus.rk_valid, bus.busy, bus.rk_idx, bus.round_key, exp_key[10]);
        end
        checks++;
        if (got_key[0] !== KEY_A1 || got_key[1] !== A1_K1 || got_key[2] !== A1_K2 ||
            got_key[10] !== A1_K10) begin
            errors++;
            $display("FAIL fips_vectors: k0=%h k1=%h k2=%h k10=%h, want %h %h %h %h",
                     got_key[0], got_key[1], got_key[2], got_key[10], KEY_A1, A1_K1, A1_K2, A1_K10);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL fips_done_pulse: done=%b one cycle later, want 0", bus.done);
        end
    endtask

    task automatic test_zero_key();
        compute_schedule(128'h0);
        bus.rk_ready = 1'b1;
        do_start(128'h0);
        for (int i = 0; i <= 10; i++) begin
            got_key[i] = bus.round_key;
            checks++;
            if (bus.rk_idx !== 4'(i) || bus.round_key !== exp_key[i]) begin
                errors++;
                $display("FAIL zero_key: idx=%0d key=%h, want idx=%0d key=%h",
                         bus.rk_idx, bus.round_key, i, exp_key[i]);
            end
            @(negedge clk);
        end
        checks++;
        if (got_key[1] !== ZERO_K1 || bus.done !== 1'b1) begin
            errors++;
            $display("FAIL zero_k1: k1=%h done=%b, want %h done=1", got_key[1], bus.done, ZERO_K1);
        end
    endtask

    task automatic test_backpressure();
        int exp_idx = 0, stall0 = 0, stall10 = 0, hs = 0, cyc = 0;
        bit finished = 0;
        logic rdy;
        compute_schedule(KEY_A1);
        bus.rk_ready = 1'b0;
        do_start(KEY_A1);
        while (!finished && cyc < 300) begin
            checks++;
            if (bus.rk_valid !== 1'b1 || bus.rk_idx !== 4'(exp_idx) || bus.round_key !== exp_key[exp_idx]) begin
                errors++;
                $display("FAIL bp_key cyc %0d: valid=%b idx=%0d key=%h, want valid=1 idx=%0d key=%h",
                         cyc, bus.rk_valid, bus.rk_idx, bus.round_key, exp_idx, exp_key[exp_idx]);
            end
            if (exp_idx == 0 && stall0 < 5) begin
                rdy = 1'b0; stall0++;
            end else if (exp_idx == 10 && stall10 < 5) begin
                rdy = 1'b0; stall10++;
            end else begin
                rdy = 1'($urandom_range(0, 1));
            end
            bus.rk_ready = rdy;
            @(negedge clk);
            cyc++;
            if (rdy) begin
                hs++;
                if (exp_idx == 10) begin
                    finished = 1;
                    checks++;
                    if (bus.done !== 1'b1 || bus.rk_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL bp_done: done=%b valid=%b, want 1 0", bus.done, bus.rk_valid);
                    end
                end else begin
                    exp_idx++;
                end
            end
        end
        checks++;
        if (!finished || hs != 11 || stall0 != 5 || stall10 != 5) begin
            errors++;
            $display("FAIL bp_sequence: finished=%0d handshakes=%0d stalls=%0d/%0d, want 1 11 5/5",
                     finished, hs, stall0, stall10);
        end
        bus.rk_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ignored_start();
        compute_schedule(KEY_A1);
        bus.rk_ready = 1'b1;
        do_start(KEY_A1);
        for (int i = 0; i <= 10; i++) begin
            checks++;
            if (bus.rk_idx !== 4'(i) || bus.round_key !== exp_key[i] || bus.rk_valid !== 1'b1) begin
                errors++;
                $display("FAIL ignored_start: valid=%b idx=%0d key=%h, want valid=1 idx=%0d key=%h",
                         bus.rk_valid, bus.rk_idx, bus.round_key, i, exp_key[i]);
            end
            bus.start  = (i == 4);
            bus.key_in = (i == 4) ? ~KEY_A1 : 128'h0;
            @(negedge clk);
        end
        bus.start = 1'b0;
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL ignored_start_done: done=%b, want 1", bus.done);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        compute_schedule(KEY_A1);
        bus.rk_ready = 1'b1;
        do_start(KEY_A1);
        repeat (11) @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || bus.round_key !== exp_key[10]) begin
            errors++;
            $display("FAIL b2b_first_done: done=%b key=%h, want 1 %h", bus.done, bus.round_key, exp_key[10]);
        end
        bus.start  = 1'b1;
        bus.key_in = 128'h0;
        compute_schedule(128'h0);
        @(negedge clk);
        bus.start  = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            checks++;
            if (bus.rk_valid !== 1'b1 || bus.rk_idx !== 4'(i) || bus.round_key !== exp_key[i] ||
                bus.done !== 1'b0) begin
                errors++;
                $display("FAIL b2b_key: valid=%b idx=%0d key=%h done=%b, want 1 %0d %h 0",
                         bus.rk_valid, bus.rk_idx, bus.round_key, bus.done, i, exp_key[i]);
            end
            @(negedge clk);
        end
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_done: done=%b, want 1", bus.done);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        bit seen_done = 0;
        compute_schedule(KEY_A1);
        bus.rk_ready = 1'b1;
        do_start(KEY_A1);
        repeat (6) @(negedge clk);
        checks++;
        if (bus.rk_idx !== 4'd6 || bus.round_key !== exp_key[6]) begin
            errors++;
            $display("FAIL areset_pre: idx=%0d key=%h, want 6 %h", bus.rk_idx, bus.round_key, exp_key[6]);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.rk_valid !== 1'b0 || bus.rk_idx !== 4'd0 || bus.round_key !== 128'h0 ||
            bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate: valid=%b idx=%0d key=%h busy=%b done=%b, want all zero",
                     bus.rk_valid, bus.rk_idx, bus.round_key, bus.busy, bus.done);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.done !== 1'b0 || bus.rk_valid !== 1'b0) seen_done = 1;
        end
        checks++;
        if (seen_done) begin
            errors++;
            $display("FAIL areset_no_done: done/valid seen after reset, want none");
        end
        do_start(KEY_A1);
        for (int i = 0; i <= 10; i++) begin
            checks++;
            if (bus.rk_valid !== 1'b1 || bus.rk_idx !== 4'(i) || bus.round_key !== exp_key[i]) begin
                errors++;
                $display("FAIL areset_restart: valid=%b idx=%0d key=%h, want 1 %0d %h",
                         bus.rk_valid, bus.rk_idx, bus.round_key, i, exp_key[i]);
            end
            @(negedge clk);
        end
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL areset_restart_done: done=%b, want 1", bus.done);
        end
        @(negedge clk);
    endtask

    initial begin
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.key_in   = 128'h0;
        bus.rk_ready = 1'b0;
        for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));
        test_reset();
        test_fips();
        test_zero_key();
        test_backpressure();
        test_ignored_start();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
